multi_accumulator: RTL and testbench
====================================

MULTI_ACCUMULATOR -- requirements
Module: multi_accumulator

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 32, accumulator and data width in bits, two's-complement signed.
- CHANNELS, 4, number of independent accumulators, minimum 1.
- SATURATE, 1, 1 = signed saturating add, 0 = wrap-around add.
REQ-002 CW SHALL equal max(1, $clog2(CHANNELS)).
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-high reset.
- clear, in, 1, synchronous clear of all channel accumulators and overflow flags.
- in_valid, in, 1, input operation offered.
- in_ready, out, 1, block can accept an operation this cycle.
- in_chan, in, CW, target channel.
- in_load, in, 1, 1 = overwrite the accumulator with in_val, 0 = add in_val.
- in_val, in, WIDTH, operand.
- in_last, in, 1, final operation for the channel; emit the result.
- out_valid, out, 1, result register holds a result.
- out_ready, in, 1, consumer takes the result.
- out_chan, out, CW, channel of the result.
- out_val, out, WIDTH, accumulated result.
- out_ovf, out, 1, sticky overflow flag for the emitted result.

Function
REQ-004 A transfer (accept) SHALL occur on any rising edge where in_valid && in_ready.
REQ-005 in_ready SHALL be combinational: !clear && (!out_valid || out_ready).
REQ-006 On accept, nxt SHALL be in_val if in_load=1, and acc[in_chan] + in_val otherwise.
REQ-007 Add overflow SHALL be detected when both operands have the same sign and the sum sign differs.
REQ-008 With SATURATE=1, an overflowing sum SHALL clamp to 2^(WIDTH-1)-1 (positive) or -2^(WIDTH-1) (negative); with SATURATE=0 it SHALL wrap modulo 2^WIDTH.
REQ-009 ovf[ch] SHALL be set by any overflowing add and SHALL be cleared only by a load, by emission, or by clear/reset; a load SHALL never set ovf.
REQ-010 On an accept with in_last=0, acc[in_chan] and ovf[in_chan] SHALL take nxt and the updated flag at that edge.
REQ-011 On an accept with in_last=1, the output register SHALL capture {in_chan, nxt, updated flag} at that edge, out_valid SHALL be 1 the next cycle (1-cycle latency), and acc[in_chan] and ovf[in_chan] SHALL go to 0.
REQ-012 Output FSM SHALL have two states.
- EMPTY -> FULL on a last-accept.
- FULL -> EMPTY on out_ready with no last-accept in the same cycle.
- FULL -> FULL (register reloaded) on out_ready together with a last-accept, giving back-to-back throughput of 1 per cycle.
REQ-013 While out_valid=1 && out_ready=0, out_chan, out_val and out_ovf SHALL hold stable.
REQ-014 An accept with in_chan >= CHANNELS SHALL complete the handshake and change no accumulator; if in_last=1 it SHALL emit out_val=0 and out_ovf=0.
REQ-015 clear SHALL zero every acc and ovf at the edge, block accepts in that cycle (REQ-005), and leave the output register and out_valid untouched.
REQ-016 Operations to different channels SHALL be independent; consecutive accepts to the same channel SHALL use the value written at the previous edge (no stale read).

Reset
REQ-017 Asserting reset SHALL immediately force out_valid=0, out_chan=0, out_val=0, out_ovf=0, all acc=0 and all ovf=0, regardless of the clock.
REQ-018 Reset asserted mid-operation SHALL discard any pending result; the first accept after deassertion SHALL behave as from power-up.

Verification
REQ-019 Benches SHALL use WIDTH=8, CHANNELS=4, SATURATE=1 unless a scenario states otherwise, and cover these scenarios.
- ch1: load 10, add 5, add -3 with last -> one cycle later out_valid=1, out_chan=1, out_val=12, out_ovf=0; acc[1]=0.
- ch0: load 100, add 100 with last -> out_val=127, out_ovf=1; same sequence with SATURATE=0 -> out_val=-56, out_ovf=1.
- out_ready=0 while a result is held -> in_ready=0 and outputs stable for 5 cycles; raise out_ready with a simultaneous last-accept -> new result the next cycle with no bubble.
- Interleave ch2 (add 3 x4) and ch3 (add -1 x4), last on each -> 12 then -4, in order.
- Issue clear between adds -> accumulator restarts at 0; in_chan=5 with last -> out_val=0 with no state change.
- Assert reset asynchronously mid-accumulation while out_valid=1 -> outputs are 0 before the next clock edge; a fresh load 7 with last -> out_val=7.

Source files
------------

// File: rtl/multi_accumulator.sv
// Multi-channel signed accumulator. Each channel can load or add an operand (saturating or
// wrapping), and an operation flagged last emits that channel's result through a one-entry output register.
module multi_accumulator #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 1,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    in_chan,
    input  logic             in_load,
    input  logic [WIDTH-1:0] in_val,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_chan,
    output logic [WIDTH-1:0] out_val,
    output logic             out_ovf
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    acc_q [CHANNELS];
    logic [WIDTH-1:0]    acc_d [CHANNELS];
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic [CW-1:0]       out_chan_q, out_chan_d;
    logic [WIDTH-1:0]    out_val_q, out_val_d;
    logic                out_ovf_q, out_ovf_d;

    logic             accept;
    logic             chan_ok;
    logic [WIDTH-1:0] cur, sum, nxt;
    logic             cur_ovf, add_ovf, nxt_ovf;

    assign in_ready  = !clear && ((state_q == EMPTY) || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == FULL);
    assign out_chan  = out_chan_q;
    assign out_val   = out_val_q;
    assign out_ovf   = out_ovf_q;

    // Channel select by compare so non-power-of-two CHANNELS never indexes past the array.
    always_comb begin
        cur     = '0;
        cur_ovf = 1'b0;
        chan_ok = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (in_chan == CW'(i)) begin
                cur     = acc_q[i];
                cur_ovf = ovf_q[i];
                chan_ok = 1'b1;
            end
        end
    end

    always_comb begin
        sum     = cur + in_val;
        add_ovf = (cur[WIDTH-1] == in_val[WIDTH-1]) && (sum[WIDTH-1] != cur[WIDTH-1]);
        nxt     = sum;
        nxt_ovf = cur_ovf | add_ovf;
        if (in_load) begin
            nxt     = in_val;
            nxt_ovf = 1'b0;
        end else if (add_ovf && (SATURATE != 0)) begin
            nxt = cur[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        if (!chan_ok) begin
            nxt     = '0;
            nxt_ovf = 1'b0;
        end
    end

    always_comb begin
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        out_chan_d = out_chan_q;
        out_val_d  = out_val_q;
        out_ovf_d  = out_ovf_q;
        state_d    = state_q;

        if (clear) begin
            for (int unsigned i = 0; i < CHANNELS; i++) acc_d[i] = '0;
            ovf_d = '0;
        end else if (accept) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (in_chan == CW'(i)) begin
                    acc_d[i] = in_last ? '0 : nxt;
                    ovf_d[i] = in_last ? 1'b0 : nxt_ovf;
                end
            end
        end

        if (accept && in_last) begin
            out_chan_d = in_chan;
            out_val_d  = nxt;
            out_ovf_d  = nxt_ovf;
        end

        case (state_q)
            EMPTY:   if (accept && in_last) state_d = FULL;
            FULL:    if (out_ready && !(accept && in_last)) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            out_chan_q <= '0;
            out_val_q  <= '0;
            out_ovf_q  <= 1'b0;
            ovf_q      <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            out_chan_q <= out_chan_d;
            out_val_q  <= out_val_d;
            out_ovf_q  <= out_ovf_d;
            ovf_q      <= ovf_d;
            for (int unsigned i = 0; i < CHANNELS; i++) acc_q[i] <= acc_d[i];
        end
    end

endmodule

// File: tb/tb_multi_accumulator.sv
// Directed bench: a saturating 4-channel instance and a wrapping 5-channel instance share the stimulus.
module tb_multi_accumulator;

    logic       clock, reset, clear;
    logic       in_valid, in_load, in_last, out_ready;
    logic [2:0] in_chan;
    logic [7:0] in_val;

    logic       in_ready_s, out_valid_s, out_ovf_s;
    logic [1:0] out_chan_s;
    logic [7:0] out_val_s;
    logic       in_ready_w, out_valid_w, out_ovf_w;
    logic [2:0] out_chan_w;
    logic [7:0] out_val_w;

    int n_tests = 0;
    int n_fail  = 0;

    multi_accumulator #(.WIDTH(8), .CHANNELS(4), .SATURATE(1)) dut_s (
        .clock(clock), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_chan(in_chan[1:0]),
        .in_load(in_load), .in_val(in_val), .in_last(in_last),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_chan(out_chan_s),
        .out_val(out_val_s), .out_ovf(out_ovf_s)
    );

    multi_accumulator #(.WIDTH(8), .CHANNELS(5), .SATURATE(0)) dut_w (
        .clock(clock), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_chan(in_chan),
        .in_load(in_load), .in_val(in_val), .in_last(in_last),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_chan(out_chan_w),
        .out_val(out_val_w), .out_ovf(out_ovf_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       ld;
        logic [2:0] ch;
        logic [7:0] v;
        logic       last;
        logic       ev;
        logic [7:0] es;
        logic       eso;
        logic [7:0] ew;
        logic       ewo;
    } vec_t;

    function automatic vec_t mk(int ld, int ch, int v, int last, int ev,
                                int es, int eso, int ew, int ewo);
        vec_t r;
        r.ld   = ld[0];
        r.ch   = 3'(ch);
        r.v    = 8'(v);
        r.last = last[0];
        r.ev   = ev[0];
        r.es   = 8'(es);
        r.eso  = eso[0];
        r.ew   = 8'(ew);
        r.ewo  = ewo[0];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic ld, input int ch, input int val, input logic last);
        in_valid = v;
        in_load  = ld;
        in_chan  = 3'(ch);
        in_val   = 8'(val);
        in_last  = last;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ev, input int ch,
                           input logic [7:0] es, input logic eso,
                           input logic [7:0] ew, input logic ewo);
        logic [2:0] c;
        c = 3'(ch);
        chk({tag, ".valid_s"}, 32'(out_valid_s), 32'(ev));
        chk({tag, ".valid_w"}, 32'(out_valid_w), 32'(ev));
        if (ev) begin
            chk({tag, ".chan_s"}, 32'(out_chan_s), 32'(c[1:0]));
            chk({tag, ".val_s"},  32'(out_val_s),  32'(es));
            chk({tag, ".ovf_s"},  32'(out_ovf_s),  32'(eso));
            chk({tag, ".chan_w"}, 32'(out_chan_w), 32'(c));
            chk({tag, ".val_w"},  32'(out_val_w),  32'(ew));
            chk({tag, ".ovf_w"},  32'(out_ovf_w),  32'(ewo));
        end
    endtask

    vec_t vecs[$];

    initial begin
        // ld, ch, val, last | expected valid, sat val/ovf, wrap val/ovf
        vecs.push_back(mk(1, 1,   10, 0, 0,    0, 0,   0, 0));
        vecs.push_back(mk(0, 1,    5, 0, 0,    0, 0,   0, 0));
        vecs.push_back(mk(0, 1,   -3, 1, 1,   12, 0,  12, 0));
        vecs.push_back(mk(0, 1,    0, 1, 1,    0, 0,   0, 0));
        vecs.push_back(mk(1, 0,  100, 0, 0,    0, 0,   0, 0));
        vecs.push_back(mk(0, 0,  100, 1, 1,  127, 1, -56, 1));
        vecs.push_back(mk(1, 0, -100, 0, 0,    0, 0,   0, 0));
        vecs.push_back(mk(0, 0, -100, 1, 1, -128, 1,  56, 1));
        vecs.push_back(mk(0, 1,  127, 0, 0,    0, 0,   0, 0));
        vecs.push_back(mk(0, 1,    1, 0, 0,    0, 0,   0, 0));
        vecs.push_back(mk(0, 1,  -10, 1, 1,  117, 1, 118, 1));
        vecs.push_back(mk(0, 1,  127, 0, 0,    0, 0,   0, 0));
        vecs.push_back(mk(0, 1,    1, 0, 0,    0, 0,   0, 0));
        vecs.push_back(mk(1, 1,    5, 0, 0,    0, 0,   0, 0));
        vecs.push_back(mk(0, 1,    1, 1, 1,    6, 0,   6, 0));
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mk(0, 2,  3, 0, 0, 0, 0, 0, 0));
            vecs.push_back(mk(0, 3, -1, 0, 0, 0, 0, 0, 0));
        end
        vecs.push_back(mk(0, 2,  3, 1, 1, 12, 0, 12, 0));
        vecs.push_back(mk(0, 3, -1, 1, 1, -4, 0, -4, 0));

        reset = 1'b1; clear = 1'b0; out_ready = 1'b1;
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        #12;
        chk_out("reset", 1'b0, 0, 8'd0, 1'b0, 8'd0, 1'b0);
        chk("reset.out_val_s", 32'(out_val_s), 32'd0);
        chk("reset.in_ready", 32'(in_ready_s), 32'd1);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].ld, int'(vecs[i].ch), int'(vecs[i].v), vecs[i].last);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].ev, int'(vecs[i].ch),
                    vecs[i].es, vecs[i].eso, vecs[i].ew, vecs[i].ewo);
        end
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        step();
        chk_out("drain", 1'b0, 0, 8'd0, 1'b0, 8'd0, 1'b0);

        // Backpressure: result held stable, then reload with no bubble.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 0, 5, 1'b1);
        step();
        chk_out("bp.first", 1'b1, 0, 8'd5, 1'b0, 8'd5, 1'b0);
        drive(1'b1, 1'b1, 1, 9, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp.in_ready%0d", k), 32'(in_ready_s), 32'd0);
            chk_out($sformatf("bp.hold%0d", k), 1'b1, 0, 8'd5, 1'b0, 8'd5, 1'b0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp.in_ready_up", 32'(in_ready_s), 32'd1);
        step();
        chk_out("bp.reload", 1'b1, 1, 8'd9, 1'b0, 8'd9, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        step();
        chk_out("bp.drain", 1'b0, 0, 8'd0, 1'b0, 8'd0, 1'b0);

        // Clear zeroes accumulators but leaves the held result alone.
        drive(1'b1, 1'b0, 2, 4, 1'b0);
        step();
        drive(1'b1, 1'b0, 3, 7, 1'b1);
        step();
        chk_out("clr.pre", 1'b1, 3, 8'd7, 1'b0, 8'd7, 1'b0);
        drive(1'b1, 1'b0, 2, 50, 1'b0);
        clear = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("clr.in_ready", 32'(in_ready_s), 32'd0);
        chk("clr.in_ready_w", 32'(in_ready_w), 32'd0);
        step();
        clear = 1'b0;
        chk_out("clr.held", 1'b1, 3, 8'd7, 1'b0, 8'd7, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        out_ready = 1'b1;
        step();
        drive(1'b1, 1'b0, 2, 3, 1'b1);
        step();
        chk_out("clr.restart", 1'b1, 2, 8'd3, 1'b0, 8'd3, 1'b0);

        // Out-of-range channel on the 5-channel instance.
        drive(1'b1, 1'b1, 1, 20, 1'b0);
        step();
        drive(1'b1, 1'b0, 5, 33, 1'b1);
        step();
        chk("oor.valid_w", 32'(out_valid_w), 32'd1);
        chk("oor.chan_w",  32'(out_chan_w),  32'd5);
        chk("oor.val_w",   32'(out_val_w),   32'd0);
        chk("oor.ovf_w",   32'(out_ovf_w),   32'd0);
        drive(1'b1, 1'b0, 1, 0, 1'b1);
        step();
        chk("oor.ch1_w", 32'(out_val_w), 32'd20);
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        step();

        // Asynchronous reset while a result is held and ch2 is mid-accumulation.
        drive(1'b1, 1'b0, 2, 9, 1'b0);
        step();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1, 3, 1'b1);
        step();
        chk_out("rst.pre", 1'b1, 1, 8'd3, 1'b0, 8'd3, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("rst.valid_s", 32'(out_valid_s), 32'd0);
        chk("rst.chan_s",  32'(out_chan_s),  32'd0);
        chk("rst.val_s",   32'(out_val_s),   32'd0);
        chk("rst.ovf_s",   32'(out_ovf_s),   32'd0);
        chk("rst.valid_w", 32'(out_valid_w), 32'd0);
        chk("rst.val_w",   32'(out_val_w),   32'd0);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 0, 7, 1'b1);
        step();
        chk_out("rst.fresh", 1'b1, 0, 8'd7, 1'b0, 8'd7, 1'b0);
        drive(1'b1, 1'b0, 2, 0, 1'b1);
        step();
        chk_out("rst.ch2_zero", 1'b1, 2, 8'd0, 1'b0, 8'd0, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 1'b0);
        step();
        chk_out("rst.drain", 1'b0, 0, 8'd0, 1'b0, 8'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
